uart_loader: RTL and testbench

Parametrised successor to the fixed-width UART programming unit. It receives a framed 8N1 byte stream on a single `uart_rx` pin and assembles little-endian words of `DATA_WIDTH` bits. Each word is written to one of `NUM_BANKS` target memories (instruction RAM, data RAM, …) at an auto-incrementing address. Each record is acknowledged on `uart_tx`, and `uart_complete` is raised when the host sends the end marker. It sits between the board UART pins and the memory programming ports, active while the CPU is held in programming mode.

---
 rtl/uart_loader_pkg.sv | 32 +++
 rtl/uart_byte_rx.sv | 96 +++++++++
 rtl/uart_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Protocol constants and state encodings shared by the UART loader and its
// byte receiver.
package uart_loader_pkg;

  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam logic [7:0] END_MARK = 8'hFF;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE_HDR,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_END
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronises the asynchronous rx pin, finds the start
// bit centre and samples data/stop bits one bit period apart.
module uart_byte_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_uart,
  input  logic       uart_rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          meta_q, sync_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk_uart or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is already high again at its centre was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync_q) valid_d = 1'b1;
          else        ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte   = shift_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// UART memory loader: parses header/count/data records into little-endian
// words, strobes them into the selected bank and answers each record with ACK/NAK.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_BANKS    = 2,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                  clk_uart,
  input  logic                  uart_rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic [ADDR_WIDTH-1:0] uart_addr,
  output logic [DATA_WIDTH-1:0] uart_data,
  output logic [NUM_BANKS-1:0]  uart_bank,
  output logic                  uart_write_enable,
  output logic                  uart_complete,
  output logic                  uart_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk_uart  (clk_uart),
    .uart_rst_n(uart_rst_n),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr)
  );

  // ---------------- parser ----------------
  parse_state_e          st_q, st_d;
  logic [NUM_BANKS-1:0]  bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic                  complete_q, error_q;
  logic                  complete_set, error_set;
  logic                  tx_req;
  logic [7:0]            tx_req_byte;
  logic [7:0]            hdr_off;

  always_ff @(posedge clk_uart or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      st_q       <= ST_IDLE_HDR;
      bank_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      cnt_lo_q   <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      cnt_lo_q   <= cnt_lo_d;
      words_q    <= words_d;
      we_q       <= we_d;
      complete_q <= complete_q | complete_set;
      error_q    <= error_q | error_set;
    end
  end

  always_comb begin
    st_d         = st_q;
    bank_d       = bank_q;
    addr_d       = we_q ? addr_q + 1'b1 : addr_q;
    data_d       = data_q;
    idx_d        = idx_q;
    cnt_lo_d     = cnt_lo_q;
    words_d      = words_q;
    we_d         = 1'b0;
    complete_set = 1'b0;
    error_set    = 1'b0;
    tx_req       = 1'b0;
    tx_req_byte  = ACK;
    hdr_off      = rx_byte - HDR_BASE;

    // A framing error abandons whatever record was in flight.
    if (rx_ferr && st_q != ST_END) begin
      error_set   = 1'b1;
      tx_req      = 1'b1;
      tx_req_byte = NAK;
      idx_d       = '0;
      st_d        = ST_IDLE_HDR;
    end else if (rx_valid) begin
      case (st_q)
        ST_IDLE_HDR: begin
          if (hdr_off < 8'(NUM_BANKS)) begin
            bank_d = NUM_BANKS'(1) << hdr_off;
            addr_d = '0;
            idx_d  = '0;
            st_d   = ST_CNT_LO;
          end else if (rx_byte == END_MARK) begin
            complete_set = 1'b1;
            tx_req       = 1'b1;
            st_d         = ST_END;
          end else begin
            error_set   = 1'b1;
            tx_req      = 1'b1;
            tx_req_byte = NAK;
          end
        end
        ST_CNT_LO: begin
          cnt_lo_d = rx_byte;
          st_d     = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          words_d = {rx_byte, cnt_lo_q};
          if ({rx_byte, cnt_lo_q} == 16'd0) begin
            tx_req = 1'b1;
            st_d   = ST_IDLE_HDR;
          end else begin
            st_d = ST_DATA;
          end
        end
        ST_DATA: begin
          for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IW'(k)) data_d[8*k +: 8] = rx_byte;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            we_d    = 1'b1;
            words_d = words_q - 16'd1;
            if (words_q == 16'd1) begin
              tx_req = 1'b1;
              st_d   = ST_IDLE_HDR;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: ; // ST_END swallows everything until reset
      endcase
    end
  end

  assign uart_addr         = addr_q;
  assign uart_data         = data_q;
  assign uart_bank         = bank_q;
  assign uart_write_enable = we_q;
  assign uart_complete     = complete_q | complete_set;
  assign uart_error        = error_q | error_set;

  // ---------------- transmitter ----------------
  tx_state_e     tx_st_q, tx_st_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          tx_load;
  logic [7:0]    tx_load_byte;

  always_ff @(posedge clk_uart or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      tx_st_q      <= TX_IDLE;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
    end else begin
      tx_st_q      <= tx_st_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
    end
  end

  always_comb begin
    tx_load      = 1'b0;
    tx_load_byte = pend_byte_q;
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    if (tx_st_q == TX_IDLE) begin
      if (pend_valid_q) begin
        tx_load      = 1'b1;
        pend_valid_d = 1'b0;
      end else if (tx_req) begin
        tx_load      = 1'b1;
        tx_load_byte = tx_req_byte;
      end
    end
    // A request not sent straight away takes the slot if it is (or just became) free.
    if (tx_req && !(tx_load && !pend_valid_q) && !pend_valid_d) begin
      pend_valid_d = 1'b1;
      pend_byte_d  = tx_req_byte;
    end
  end

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_load) begin
          tx_shift_d = tx_load_byte;
          tx_st_d    = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = TX_IDLE;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_st_q)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: a default-width instance (A) and a narrow
// 16-bit / 2-bit-address instance (B) for address wrap.
module tb_uart_loader;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  logic clk_uart   = 1'b0;
  logic uart_rst_n = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;

  logic        tx_a, we_a, comp_a, err_a;
  logic [13:0] addr_a;
  logic [31:0] data_a;
  logic [1:0]  bank_a;

  logic        tx_b, we_b, comp_b, err_b;
  logic [1:0]  addr_b;
  logic [15:0] data_b;
  logic [1:0]  bank_b;

  always #(CLK_NS/2) clk_uart = ~clk_uart;

  uart_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .NUM_BANKS(2), .CLKS_PER_BIT(CPB)) dut_a (
    .clk_uart(clk_uart), .uart_rst_n(uart_rst_n), .uart_rx(rx_a), .uart_tx(tx_a),
    .uart_addr(addr_a), .uart_data(data_a), .uart_bank(bank_a),
    .uart_write_enable(we_a), .uart_complete(comp_a), .uart_error(err_a)
  );

  uart_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_BANKS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .clk_uart(clk_uart), .uart_rst_n(uart_rst_n), .uart_rx(rx_b), .uart_tx(tx_b),
    .uart_addr(addr_b), .uart_data(data_b), .uart_bank(bank_b),
    .uart_write_enable(we_b), .uart_complete(comp_b), .uart_error(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [63:0] wr_a_q[$];
  logic [63:0] wr_b_q[$];
  logic [7:0]  tx_a_q[$];

  // Write strobes captured as {bank, addr(14), data(32)}, narrow DUT zero-extended.
  always @(negedge clk_uart) begin
    if (we_a) wr_a_q.push_back({16'd0, bank_a, addr_a, data_a});
    if (we_b) wr_b_q.push_back({16'd0, bank_b, 12'd0, addr_b, 16'd0, data_b});
  end

  // Serial decoder for DUT A's acknowledge line.
  initial begin
    forever begin
      logic [7:0] b;
      @(negedge tx_a);
      if (mon_en) begin
        #(BIT_NS/2);
        for (int i = 0; i < 8; i++) begin
          #(BIT_NS);
          b[i] = tx_a;
        end
        #(BIT_NS);
        tx_a_q.push_back(b);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
    set_rx(sel, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      #(BIT_NS);
    end
    set_rx(sel, stop);
    #(BIT_NS);
    set_rx(sel, 1'b1);
    #(BIT_NS);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [63:0] got;
    got = 64'h1FF;
    for (int t = 0; t < 40 && tx_a_q.size() == 0; t++) #(BIT_NS);
    if (tx_a_q.size() > 0) got = 64'(tx_a_q.pop_front());
    check_eq(tag, got, 64'(exp));
  endtask

  task automatic expect_wr(input bit sel, input string tag, input logic [1:0] bank,
                           input logic [13:0] addr, input logic [31:0] data);
    logic [63:0] got;
    got = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int t = 0; t < 4 && (sel ? wr_b_q.size() : wr_a_q.size()) == 0; t++) #(BIT_NS);
    if (sel && wr_b_q.size() > 0)       got = wr_b_q.pop_front();
    else if (!sel && wr_a_q.size() > 0) got = wr_a_q.pop_front();
    check_eq(tag, got, {16'd0, bank, addr, data});
  endtask

  logic [7:0] rec1 [0:10] = '{8'hA0, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                              8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] rec3 [0:6]  = '{8'hA0, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rec4 [0:6]  = '{8'hA1, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] rec5 [0:6]  = '{8'hA0, 8'h01, 8'h00, 8'hC0, 8'hFF, 8'hEE, 8'h00};
  logic [7:0] rec6 [0:6]  = '{8'hA0, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    #3 uart_rst_n = 1'b0;
    #(CLK_NS*3);
    check_eq("rst_tx",    64'(tx_a),   64'd1);
    check_eq("rst_we",    64'(we_a),   64'd0);
    check_eq("rst_comp",  64'(comp_a), 64'd0);
    check_eq("rst_err",   64'(err_a),  64'd0);
    check_eq("rst_addr",  64'(addr_a), 64'd0);
    check_eq("rst_data",  64'(data_a), 64'd0);
    check_eq("rst_bank",  64'(bank_a), 64'd0);
    @(negedge clk_uart) uart_rst_n = 1'b1;
    mon_en = 1'b1;
    #(BIT_NS*2);

    // Two-word record into bank 0.
    for (int i = 0; i < 11; i++) send_byte(1'b0, rec1[i], 1'b1);
    expect_wr(1'b0, "t1_w0", 2'b01, 14'd0, 32'hDEADBEEF);
    expect_wr(1'b0, "t1_w1", 2'b01, 14'd1, 32'h01234567);
    check_eq("t1_addr_inc", 64'(addr_a), 64'd2);
    check_eq("t1_err", 64'(err_a), 64'd0);
    expect_tx("t1_ack", 8'h06);

    // Address wrap on the narrow instance: five 16-bit words, 2-bit address.
    send_byte(1'b1, 8'hA0, 1'b1);
    send_byte(1'b1, 8'h05, 1'b1);
    send_byte(1'b1, 8'h00, 1'b1);
    for (int w = 0; w < 5; w++) begin
      send_byte(1'b1, 8'(w), 1'b1);
      send_byte(1'b1, 8'hA5, 1'b1);
    end
    for (int w = 0; w < 5; w++)
      expect_wr(1'b1, $sformatf("wrap_w%0d", w), 2'b01, 14'(w % 4), 32'hA500 + 32'(w));
    check_eq("wrap_extra", 64'(wr_b_q.size()), 64'd0);
    #(BIT_NS*12);
    check_eq("wrap_err",  64'(err_b),  64'd0);
    check_eq("wrap_comp", 64'(comp_b), 64'd0);
    check_eq("wrap_tx_idle", 64'(tx_b), 64'd1);

    // Bad header, then a valid record.
    send_byte(1'b0, 8'h55, 1'b1);
    check_eq("t3_err", 64'(err_a), 64'd1);
    expect_tx("t3_nak", 8'h15);
    for (int i = 0; i < 7; i++) send_byte(1'b0, rec3[i], 1'b1);
    expect_wr(1'b0, "t3_w0", 2'b01, 14'd0, 32'h44332211);
    expect_tx("t3_ack", 8'h06);

    // Framing error on the third data byte of a word.
    send_byte(1'b0, 8'hA1, 1'b1);
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'hAA, 1'b1);
    send_byte(1'b0, 8'hBB, 1'b1);
    send_byte(1'b0, 8'hCC, 1'b0);
    check_eq("t4_no_wr", 64'(wr_a_q.size()), 64'd0);
    check_eq("t4_we", 64'(we_a), 64'd0);
    expect_tx("t4_nak", 8'h15);
    for (int i = 0; i < 7; i++) send_byte(1'b0, rec4[i], 1'b1);
    expect_wr(1'b0, "t4_w0", 2'b10, 14'd0, 32'h12345678);
    expect_tx("t4_ack", 8'h06);

    // Reset in the middle of a data byte.
    send_byte(1'b0, 8'hA0, 1'b1);
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'hEF, 1'b1);
    send_byte(1'b0, 8'hBE, 1'b1);
    rx_a = 1'b0;
    #(BIT_NS);
    rx_a = 1'b1;
    #(BIT_NS/2);
    uart_rst_n = 1'b0;
    #1;
    check_eq("mrst_err",  64'(err_a),  64'd0);
    check_eq("mrst_we",   64'(we_a),   64'd0);
    check_eq("mrst_tx",   64'(tx_a),   64'd1);
    check_eq("mrst_addr", 64'(addr_a), 64'd0);
    check_eq("mrst_data", 64'(data_a), 64'd0);
    check_eq("mrst_bank", 64'(bank_a), 64'd0);
    #(BIT_NS);
    @(negedge clk_uart) uart_rst_n = 1'b1;
    #(BIT_NS*12);
    for (int i = 0; i < 7; i++) send_byte(1'b0, rec5[i], 1'b1);
    expect_wr(1'b0, "mrst_w0", 2'b01, 14'd0, 32'h00EEFFC0);
    expect_tx("mrst_ack", 8'h06);
    check_eq("mrst_extra", 64'(wr_a_q.size()), 64'd0);

    // Empty record, end marker, then everything is ignored.
    send_byte(1'b0, 8'hA1, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    expect_tx("t2_ack0", 8'h06);
    check_eq("t2_no_wr0", 64'(wr_a_q.size()), 64'd0);
    check_eq("t2_comp_pre", 64'(comp_a), 64'd0);
    send_byte(1'b0, 8'hFF, 1'b1);
    check_eq("t2_comp", 64'(comp_a), 64'd1);
    expect_tx("t2_ack_end", 8'h06);
    for (int i = 0; i < 7; i++) send_byte(1'b0, rec6[i], 1'b1);
    #(BIT_NS*12);
    check_eq("t2_ignored_wr", 64'(wr_a_q.size()), 64'd0);
    check_eq("t2_ignored_tx", 64'(tx_a_q.size()), 64'd0);
    check_eq("t2_comp_hold", 64'(comp_a), 64'd1);
    check_eq("t2_err", 64'(err_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
